vga_scanout: RTL and testbench

Display-side scanout stage that sits directly downstream of `mide_cpu`. It generates 640x480 VGA timing and drives the processor's VRAM read port (`gpu_address`). It consumes the returned 8-bit grayscale pixel (`vram_out`) and outputs a registered RGB stream with aligned sync and blank. The interpolated image is placed at a fixed window on screen; pixels outside the window are forced to the border value.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_timing.sv | 60 ++++++
 rtl/vga_scanout.sv | 144 ++++++++++++++
 tb/tb_vga_scanout.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, derived totals/sync windows and the coordinate type
// for the scanout slice.
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
    localparam int unsigned V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

    function automatic logic in_range(input int unsigned v, input int unsigned lo,
                                      input int unsigned hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel prescaler, horizontal/vertical counters and the raw active/sync flags
// for the counter position currently being fetched.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic   clk,
    input  logic   reset,
    output logic   pix_en,
    output coord_t hc,
    output coord_t vc,
    output logic   active,
    output logic   hs_n,
    output logic   vs_n,
    output logic   frame_end
);

    localparam int unsigned HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HSS = H_ACTIVE + H_FP;
    localparam int unsigned VSS = V_ACTIVE + V_FP;

    logic [2:0] psc;

    always_comb begin
        pix_en    = (psc == 3'(CLK_DIV - 1));
        active    = in_range(32'(hc), 0, H_ACTIVE) && in_range(32'(vc), 0, V_ACTIVE);
        hs_n      = !in_range(32'(hc), HSS, HSS + H_SYNC);
        vs_n      = !in_range(32'(vc), VSS, VSS + V_SYNC);
        frame_end = (hc == coord_t'(HT - 1)) && (vc == coord_t'(VT - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            psc <= '0;
            hc  <= '0;
            vc  <= '0;
        end else begin
            psc <= pix_en ? '0 : psc + 3'd1;
            if (pix_en) begin
                if (hc == coord_t'(HT - 1)) begin
                    hc <= '0;
                    vc <= (vc == coord_t'(VT - 1)) ? '0 : vc + coord_t'(1);
                end else begin
                    hc <= hc + coord_t'(1);
                end
            end
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: drives the VRAM read address for the image window and produces
// a registered grayscale RGB stream with aligned sync, blank and coordinates.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter int unsigned IMG_W     = 256,
    parameter int unsigned IMG_H     = 256,
    parameter int unsigned X0        = 0,
    parameter int unsigned Y0        = 0,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  BORDER    = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] gpu_address,
    input  logic [7:0]  vram_out,
    output logic [23:0] rgb_out,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        blank,
    output logic        frame_start,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y
);

    logic   pix_en, active, hs_n, vs_n, frame_end, in_img;
    coord_t hc, vc;

    vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .hc        (hc),
        .vc        (vc),
        .active    (active),
        .hs_n      (hs_n),
        .vs_n      (vs_n),
        .frame_end (frame_end)
    );

    // Window is clipped to the visible area so the address only advances for shown pixels.
    assign in_img = active && in_range(32'(hc), X0, X0 + IMG_W)
                           && in_range(32'(vc), Y0, Y0 + IMG_H);

    logic [31:0] addr, addr_hold;

    // Reload happens on the tick that wraps into (0,0), so addr is already BASE_ADDR there.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr      <= BASE_ADDR;
            addr_hold <= BASE_ADDR;
        end else begin
            if (in_img)
                addr_hold <= addr;
            if (pix_en) begin
                if (frame_end)
                    addr <= BASE_ADDR;
                else if (in_img)
                    addr <= addr + 32'd1;
            end
        end
    end

    assign gpu_address = in_img ? addr : addr_hold;

    logic       s1_vld, s1_img, s1_act, s1_hs_n, s1_vs_n;
    coord_t     s1_hc, s1_vc;
    logic [7:0] s1_pix;

    // vram_out is captured with the stage-1 tick, CLK_DIV clks after its address was issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_img  <= 1'b0;
            s1_act  <= 1'b0;
            s1_hs_n <= 1'b1;
            s1_vs_n <= 1'b1;
            s1_hc   <= '0;
            s1_vc   <= '0;
            s1_pix  <= '0;
        end else if (pix_en) begin
            s1_vld  <= 1'b1;
            s1_img  <= in_img;
            s1_act  <= active;
            s1_hs_n <= hs_n;
            s1_vs_n <= vs_n;
            s1_hc   <= hc;
            s1_vc   <= vc;
            s1_pix  <= vram_out;
        end
    end

    logic [7:0] gray;

    always_comb begin
        gray = 8'h00;
        if (s1_img)
            gray = s1_pix;
        else if (s1_act)
            gray = BORDER;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_out     <= '0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            blank       <= 1'b1;
            frame_start <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
        end else begin
            frame_start <= pix_en && s1_vld && (s1_hc == '0) && (s1_vc == '0);
            if (pix_en) begin
                rgb_out <= {3{gray}};
                hsync_n <= s1_hs_n;
                vsync_n <= s1_vs_n;
                blank   <= !s1_act;
                pix_x   <= s1_hc;
                pix_y   <= s1_vc;
            end
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a shrunken raster with a window clipped
// at the right and bottom edges.
module tb_vga_scanout;

    localparam int unsigned CLK_DIV  = 2;
    localparam int unsigned H_ACTIVE = 40;
    localparam int unsigned H_FP     = 4;
    localparam int unsigned H_SYNC   = 6;
    localparam int unsigned H_BP     = 10;
    localparam int unsigned V_ACTIVE = 12;
    localparam int unsigned V_FP     = 2;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 4;
    localparam int unsigned IMG_W    = 16;
    localparam int unsigned IMG_H    = 16;
    localparam int unsigned X0       = 30;
    localparam int unsigned Y0       = 4;
    localparam logic [31:0] BASE     = 32'h0000_0100;
    localparam logic [7:0]  BORDER   = 8'h40;

    localparam int unsigned HT         = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT         = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned FRAME_CLKS = HT * VT * CLK_DIV;
    localparam int unsigned VIS_W      = H_ACTIVE - X0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] gpu_address;
    logic [7:0]  vram_out = 8'h00;
    logic [23:0] rgb_out;
    logic        hsync_n, vsync_n, blank, frame_start;
    logic [9:0]  pix_x, pix_y;

    vga_scanout #(
        .CLK_DIV   (CLK_DIV),
        .H_ACTIVE  (H_ACTIVE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_ACTIVE  (V_ACTIVE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP),
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .X0        (X0),
        .Y0        (Y0),
        .BASE_ADDR (BASE),
        .BORDER    (BORDER)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .gpu_address (gpu_address),
        .vram_out    (vram_out),
        .rgb_out     (rgb_out),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .blank       (blank),
        .frame_start (frame_start),
        .pix_x       (pix_x),
        .pix_y       (pix_y)
    );

    always #5 clk = ~clk;

    // VRAM with one clk of read latency; data is a scrambled copy of the address.
    always @(posedge clk) vram_out <= gpu_address[7:0] ^ 8'h5A;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit f_act(input int unsigned h, input int unsigned v);
        return (h < H_ACTIVE) && (v < V_ACTIVE);
    endfunction

    function automatic bit f_img(input int unsigned h, input int unsigned v);
        return f_act(h, v) && (h >= X0) && (h < X0 + IMG_W) && (v >= Y0) && (v < Y0 + IMG_H);
    endfunction

    function automatic logic [31:0] f_addr(input int unsigned h, input int unsigned v);
        return BASE + 32'((v - Y0) * VIS_W + (h - X0));
    endfunction

    // {rgb, blank, hsync_n, vsync_n, x, y}
    function automatic logic [46:0] expect_px(input int unsigned h, input int unsigned v);
        logic [7:0] g;
        logic [31:0] a;
        logic hs, vs;
        a  = f_addr(h, v);
        g  = f_img(h, v) ? (a[7:0] ^ 8'h5A) : (f_act(h, v) ? BORDER : 8'h00);
        hs = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
        vs = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
        return {g, g, g, !f_act(h, v), hs, vs, 10'(h), 10'(v)};
    endfunction

    localparam logic [46:0] RST_VEC = {24'h000000, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};

    wire [46:0] dut_vec = {rgb_out, blank, hsync_n, vsync_n, pix_x, pix_y};

    // Reference raster position for the current clk cycle.
    int unsigned m_psc = 0, m_hc = 0, m_vc = 0;
    bit          m_rst = 1'b1;
    longint      cyc = 0, rst_cyc = 0;

    always @(posedge clk) begin
        cyc++;
        m_rst = reset;
        if (reset) begin
            m_psc = 0; m_hc = 0; m_vc = 0;
            rst_cyc = cyc;
        end else if (m_psc == CLK_DIV - 1) begin
            m_psc = 0;
            if (m_hc == HT - 1) begin
                m_hc = 0;
                m_vc = (m_vc == VT - 1) ? 0 : m_vc + 1;
            end else begin
                m_hc++;
            end
        end else begin
            m_psc++;
        end
    end

    logic [46:0] exp_q[$];
    logic [31:0] m_last = BASE;
    int          fs_cnt = 0;
    bit          have_fs = 1'b0;
    longint      last_fs = 0;

    always @(negedge clk) begin
        if (m_rst) begin
            exp_q.delete();
            m_last  = BASE;
            fs_cnt  = 0;
            have_fs = 1'b0;
        end else begin
            if (frame_start) begin
                check_val("fs_xy", 64'({pix_x, pix_y}), 64'd0);
                check_val("fs_gap", 64'(have_fs ? cyc - last_fs : cyc - rst_cyc),
                          64'(have_fs ? FRAME_CLKS : 2 * CLK_DIV));
                last_fs = cyc;
                have_fs = 1'b1;
                fs_cnt++;
            end
            if (m_psc == CLK_DIV - 1) begin
                check_val("fs_low", 64'(frame_start), 64'd0);
                if (f_img(m_hc, m_vc))
                    m_last = f_addr(m_hc, m_vc);
                check_val("gpu_addr", 64'(gpu_address), 64'(m_last));
                if (exp_q.size() == 2)
                    check_val("pixel", 64'(dut_vec), 64'(exp_q.pop_front()));
                exp_q.push_back(expect_px(m_hc, m_vc));
            end
        end
    end

    initial begin
        bit found;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out", 64'(dut_vec), 64'(RST_VEC));
        check_val("rst_gpu", 64'(gpu_address), 64'(BASE));
        check_val("rst_fs", 64'(frame_start), 64'd0);
        reset = 1'b0;

        repeat (2 * FRAME_CLKS + 200) @(posedge clk);
        #1;
        check_val("fs_cnt_run1", 64'(fs_cnt), 64'd3);

        found = 1'b0;
        for (int i = 0; i < int'(2 * FRAME_CLKS); i++) begin
            @(posedge clk);
            #1;
            if (m_hc == 20 && m_vc == 6) begin
                found = 1'b1;
                break;
            end
        end
        check_val("wait_mid", 64'(found), 64'd1);

        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("mid_rst_out", 64'(dut_vec), 64'(RST_VEC));
        check_val("mid_rst_gpu", 64'(gpu_address), 64'(BASE));
        check_val("mid_rst_fs", 64'(frame_start), 64'd0);
        reset = 1'b0;

        repeat (2 * FRAME_CLKS + 200) @(posedge clk);
        #1;
        check_val("fs_cnt_run2", 64'(fs_cnt), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
